// File: rtl/muladd_issue_ctrl.sv
// Issue controller for the ADD / MULT / MULADD unit: accepts one op from decode,
// starts the unit, waits for completion under a watchdog, then hands the result to writeback.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module muladd_issue_ctrl #(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int TAG_W     = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [WORD_SIZE-1:0] in_src1,
    input  logic [WORD_SIZE-1:0] in_src2,
    input  logic [WORD_SIZE-1:0] in_src3,
    input  logic [TAG_W-1:0]     in_tag,

    output logic                 fu_start,
    output logic [1:0]           fu_sel,
    output logic [WORD_SIZE-1:0] fu_a,
    output logic [WORD_SIZE-1:0] fu_b,
    output logic [WORD_SIZE-1:0] fu_c,
    input  logic                 fu_done,
    input  logic [WORD_SIZE-1:0] fu_result,

    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_W-1:0]     wb_tag,
    output logic [WORD_SIZE-1:0] wb_data,

    output logic                 busy,
    output logic                 err_illegal,
    output logic                 err_timeout,
    output logic [15:0]          ops_done
);

    localparam logic [1:0] OP_MULADD  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        WB
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [TAG_W-1:0]   tag_q;

    // in_ready is held low during reset so decode never sees a spurious accept window.
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            tag_q       <= '0;
            fu_start    <= 1'b0;
            fu_sel      <= 2'b00;
            fu_a        <= '0;
            fu_b        <= '0;
            fu_c        <= '0;
            wb_valid    <= 1'b0;
            wb_tag      <= '0;
            wb_data     <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            ops_done    <= 16'd0;
        end else begin
            fu_start    <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_op == OP_ILLEGAL) begin
                            err_illegal <= 1'b1;
                        end else begin
                            fu_sel   <= in_op;
                            fu_a     <= in_src1;
                            fu_b     <= in_src2;
                            fu_c     <= (in_op == OP_MULADD) ? in_src3 : '0;
                            tag_q    <= in_tag;
                            fu_start <= 1'b1;
                            state    <= START;
                        end
                    end
                end

                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                // A done strobe in the last allowed cycle still counts as a real result.
                WAIT: begin
                    if (fu_done) begin
                        wb_data  <= fu_result;
                        wb_tag   <= tag_q;
                        wb_valid <= 1'b1;
                        state    <= WB;
                    end else if (wait_cnt == LAST_WAIT) begin
                        wb_data     <= '0;
                        wb_tag      <= tag_q;
                        wb_valid    <= 1'b1;
                        err_timeout <= 1'b1;
                        state       <= WB;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        ops_done <= ops_done + 16'd1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muladd_issue_ctrl.sv
// Bench for muladd_issue_ctrl: directed op sequences, a cycle-timestamp model
// compared against every output each cycle, plus literal expectations from hand timing.
module tb_muladd_issue_ctrl;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_src1, in_src2, in_src3;
    logic [TW-1:0] in_tag;
    logic          fu_start;
    logic [1:0]    fu_sel;
    logic [W-1:0]  fu_a, fu_b, fu_c;
    logic          fu_done;
    logic [W-1:0]  fu_result;
    logic          wb_valid;
    logic          wb_ready;
    logic [TW-1:0] wb_tag;
    logic [W-1:0]  wb_data;
    logic          busy;
    logic          err_illegal;
    logic          err_timeout;
    logic [15:0]   ops_done;

    muladd_issue_ctrl #(
        .WORD_SIZE(W),
        .TAG_W    (TW),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_src3    (in_src3),
        .in_tag     (in_tag),
        .fu_start   (fu_start),
        .fu_sel     (fu_sel),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_c       (fu_c),
        .fu_done    (fu_done),
        .fu_result  (fu_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_tag     (wb_tag),
        .wb_data    (wb_data),
        .busy       (busy),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: one outstanding op described by its accept cycle and whether it has finished.
    bit            m_have = 0;
    bit            m_fin  = 0;
    int            m_acc  = 0;
    logic [TW-1:0] m_tag  = '0;
    logic          m_fu_start = 0, m_err_ill = 0, m_err_to = 0;
    logic [1:0]    m_fu_sel = '0;
    logic [W-1:0]  m_fu_a = '0, m_fu_b = '0, m_fu_c = '0;
    logic [TW-1:0] m_wb_tag = '0;
    logic [W-1:0]  m_wb_data = '0;
    logic [15:0]   m_ops = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: wait bound expired, got no event, expected event (cycle %0d)", name, cyc);
    endtask

    task automatic modelStep();
        m_fu_start = 0;
        m_err_ill  = 0;
        m_err_to   = 0;
        if (rst) begin
            m_have = 0; m_fin = 0; m_tag = '0;
            m_fu_sel = '0; m_fu_a = '0; m_fu_b = '0; m_fu_c = '0;
            m_wb_tag = '0; m_wb_data = '0; m_ops = '0;
        end else if (!m_have) begin
            if (in_valid) begin
                if (in_op == 2'b11) begin
                    m_err_ill = 1;
                end else begin
                    m_have = 1; m_fin = 0; m_acc = cyc;
                    m_fu_sel = in_op; m_fu_a = in_src1; m_fu_b = in_src2;
                    m_fu_c = (in_op == 2'b10) ? in_src3 : '0;
                    m_tag = in_tag;
                    m_fu_start = 1;
                end
            end
        end else if (!m_fin) begin
            // The unit is being waited on from two cycles after accept; earlier strobes are ignored.
            if (cyc >= m_acc + 2) begin
                if (fu_done) begin
                    m_fin = 1; m_wb_data = fu_result; m_wb_tag = m_tag;
                end else if (cyc - (m_acc + 2) == TO - 1) begin
                    m_fin = 1; m_wb_data = '0; m_wb_tag = m_tag; m_err_to = 1;
                end
            end
        end else if (wb_ready) begin
            m_have = 0; m_fin = 0;
            m_ops = m_ops + 16'd1;
        end
    endtask

    always @(posedge clk) begin
        modelStep();
        cyc++;
        #1;
        checkOutput("in_ready",    32'(in_ready),    32'(!m_have && !rst));
        checkOutput("busy",        32'(busy),        32'(m_have));
        checkOutput("fu_start",    32'(fu_start),    32'(m_fu_start));
        checkOutput("fu_sel",      32'(fu_sel),      32'(m_fu_sel));
        checkOutput("fu_a",        fu_a,             m_fu_a);
        checkOutput("fu_b",        fu_b,             m_fu_b);
        checkOutput("fu_c",        fu_c,             m_fu_c);
        checkOutput("wb_valid",    32'(wb_valid),    32'(m_have && m_fin));
        checkOutput("err_illegal", 32'(err_illegal), 32'(m_err_ill));
        checkOutput("err_timeout", 32'(err_timeout), 32'(m_err_to));
        checkOutput("ops_done",    32'(ops_done),    32'(m_ops));
        if ((m_have && m_fin) || rst) begin
            checkOutput("wb_tag",  32'(wb_tag),      32'(m_wb_tag));
            checkOutput("wb_data", wb_data,          m_wb_data);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one op and returns in the cycle after the accept edge (cycle 1).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] s3, input logic [TW-1:0] tag);
        int budget = 20;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!in_ready) reportTimeout("accept_wait");
        in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2; in_src3 = s3; in_tag = tag;
        tick();
        in_valid = 1'b0;
        in_src1 = 32'h5A5A_0001; in_src2 = 32'h5A5A_0002; in_src3 = 32'h5A5A_0003; in_tag = 5'd30;
    endtask

    task automatic pulseDone(input logic [31:0] r);
        fu_done = 1'b1; fu_result = r;
        tick();
        fu_done = 1'b0; fu_result = 32'h0BAD_0BAD;
    endtask

    task automatic waitWb(input int budget, output int lat);
        lat = 0;
        while (!wb_valid && lat < budget) begin
            tick();
            lat++;
        end
        if (!wb_valid) reportTimeout("wb_wait");
    endtask

    task automatic handshake();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src1 = '0; in_src2 = '0; in_src3 = '0;
        in_tag = '0; fu_done = 1'b0; fu_result = '0; wb_ready = 1'b0;
        repeat (3) tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_ops_done", 32'(ops_done), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] MULADD 3*4+5 tag 7");
        applyStimulus(2'b10, 32'd3, 32'd4, 32'd5, 5'd7);
        checkOutput("muladd_start_c1", 32'(fu_start), 32'd1);
        checkOutput("muladd_fu_c",     fu_c, 32'd5);
        checkOutput("muladd_fu_sel",   32'(fu_sel), 32'd2);
        tick();
        checkOutput("muladd_start_c2", 32'(fu_start), 32'd0);
        tick();
        pulseDone(32'd17);
        checkOutput("muladd_wb_valid_c4", 32'(wb_valid), 32'd1);
        checkOutput("muladd_wb_tag",      32'(wb_tag), 32'd7);
        checkOutput("muladd_wb_data",     wb_data, 32'd17);
        handshake();
        checkOutput("muladd_ops_done", 32'(ops_done), 32'd1);
        checkOutput("muladd_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] ADD with src3 DEADBEEF, minimum latency");
        applyStimulus(2'b00, 32'd10, 32'd20, 32'hDEAD_BEEF, 5'd3);
        checkOutput("add_fu_c",   fu_c, 32'd0);
        checkOutput("add_fu_sel", 32'(fu_sel), 32'd0);
        tick();
        pulseDone(32'd30);
        checkOutput("add_wb_valid_c3", 32'(wb_valid), 32'd1);
        checkOutput("add_wb_data",     wb_data, 32'd30);
        checkOutput("add_fu_c_held",   fu_c, 32'd0);
        handshake();

        $display("[TB] MULT with early done strobe ignored");
        applyStimulus(2'b01, 32'd6, 32'd7, 32'd9, 5'd12);
        fu_done = 1'b1; fu_result = 32'd999;
        tick();
        fu_done = 1'b0;
        tick();
        pulseDone(32'd42);
        checkOutput("mult_wb_data", wb_data, 32'd42);
        checkOutput("mult_wb_tag",  32'(wb_tag), 32'd12);
        checkOutput("mult_fu_c",    fu_c, 32'd0);
        handshake();

        $display("[TB] illegal op");
        applyStimulus(2'b11, 32'd1, 32'd2, 32'd3, 5'd1);
        checkOutput("ill_err_pulse", 32'(err_illegal), 32'd1);
        checkOutput("ill_in_ready",  32'(in_ready), 32'd1);
        checkOutput("ill_no_start",  32'(fu_start), 32'd0);
        tick();
        checkOutput("ill_err_clear", 32'(err_illegal), 32'd0);
        checkOutput("ill_ops_done",  32'(ops_done), 32'd3);

        $display("[TB] watchdog expiry");
        applyStimulus(2'b10, 32'd1, 32'd2, 32'd3, 5'd9);
        waitWb(20, lat);
        checkOutput("to_latency",  32'(lat), 32'd5);
        checkOutput("to_err",      32'(err_timeout), 32'd1);
        checkOutput("to_wb_data",  wb_data, 32'd0);
        checkOutput("to_wb_tag",   32'(wb_tag), 32'd9);
        tick();
        checkOutput("to_err_clear", 32'(err_timeout), 32'd0);
        handshake();

        $display("[TB] done on last allowed wait cycle");
        applyStimulus(2'b00, 32'd70, 32'd7, 32'd0, 5'd10);
        repeat (4) tick();
        pulseDone(32'd77);
        checkOutput("last_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("last_wb_data",  wb_data, 32'd77);
        checkOutput("last_no_err",   32'(err_timeout), 32'd0);
        handshake();

        $display("[TB] writeback backpressure");
        applyStimulus(2'b00, 32'd500, 32'd55, 32'd1, 5'd21);
        tick();
        pulseDone(32'd555);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("bp_wb_tag",   32'(wb_tag), 32'd21);
            checkOutput("bp_wb_data",  wb_data, 32'd555);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            fu_done = (i % 3 == 1); fu_result = 32'h1000 + 32'(i);
            tick();
        end
        fu_done = 1'b0;
        handshake();
        checkOutput("bp_ops_done", 32'(ops_done), 32'd6);

        $display("[TB] reset during wait, late done");
        applyStimulus(2'b10, 32'd8, 32'd9, 32'd10, 5'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulseDone(32'd1234);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_busy",     32'(busy), 32'd0);
        checkOutput("rst_ops_done", 32'(ops_done), 32'd0);
        checkOutput("rst_fu_a",     fu_a, 32'd0);
        repeat (3) tick();

        $display("[TB] ops_done wrap");
        force dut.ops_done = 16'hFFFF;
        release dut.ops_done;
        m_ops = 16'hFFFF;
        tick();
        checkOutput("wrap_preload", 32'(ops_done), 32'h0000_FFFF);
        applyStimulus(2'b00, 32'd1, 32'd1, 32'd0, 5'd1);
        tick();
        pulseDone(32'd2);
        handshake();
        checkOutput("wrap_ops_done", 32'(ops_done), 32'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
